// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide unit: funct3 encodings, FSM state
// type, default operand width and small funct3 decode helpers.
package div_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Only DIV and REM interpret operands as two's complement; any code that
    // is not one of the four M-extension divides behaves as DIVU.
    function automatic logic f3_is_signed(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, dvd} left by
// one, trial-subtract the divisor from the widened partial remainder, keep
// the difference when it is non-negative and shift the quotient bit into dvd.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] dvd_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          q_bit;

    // The partial remainder is always below the divisor, so after the shift
    // it is below 2*divisor and the XLEN+1 bit difference cannot overflow;
    // its top bit is therefore a clean borrow flag.
    assign shifted = {rem, dvd[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[XLEN];

    // Restore mux, bit by bit: keep the trial difference only when it fit.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_restore
            assign rem_next[gi] = q_bit ? trial[gi] : shifted[gi];
        end
    endgenerate

    assign dvd_next = {dvd[XLEN-2:0], q_bit};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes on entry, one quotient bit is produced
// per cycle, and signs are restored in a single fix-up cycle. Divide-by-zero
// and signed overflow are resolved on entry without iterating.
// Optional build macro: DIV_EARLY_OUT_EN -- when defined, operations with
// |a| < |b| skip the iteration loop (quotient 0, remainder |a|).
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            write,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam int ITER_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state_reg, state_next;

    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   dvd_reg;
    logic [XLEN-1:0]   divisor_reg;
    logic [ITER_W-1:0] cnt_reg;
    logic [2:0]        funct3_reg;
    logic [4:0]        rd_cap_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic [4:0]        rd_out_reg;
    logic [XLEN-1:0]   result_reg;

    // Entry decode of the raw register-file operands.
    logic            in_signed;
    logic            in_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            early_out;
    logic            accept;

    assign in_signed   = f3_is_signed(funct3);
    assign in_rem      = f3_is_rem(funct3);
    assign a_neg       = in_signed & op_a[XLEN-1];
    assign b_neg       = in_signed & op_b[XLEN-1];
    assign a_mag       = a_neg ? ({XLEN{1'b0}} - op_a) : op_a;
    assign b_mag       = b_neg ? ({XLEN{1'b0}} - op_b) : op_b;
    assign div_by_zero = (op_b == {XLEN{1'b0}});
    assign overflow    = in_signed && (op_a == MIN_INT) && (op_b == {XLEN{1'b1}});
    assign special     = div_by_zero || overflow;
    // Divide by zero: q = all ones, r = dividend. Overflow: q = MIN_INT, r = 0.
    assign special_res = in_rem ? (div_by_zero ? op_a : {XLEN{1'b0}})
                                : (div_by_zero ? {XLEN{1'b1}} : MIN_INT);
    assign accept      = (state_reg == IDLE) && start && !kill;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (a_mag < b_mag);
`else
    assign early_out = 1'b0;
`endif

    // Iteration datapath.
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_dvd;

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem     (rem_reg),
        .dvd     (dvd_reg),
        .divisor (divisor_reg),
        .rem_next(step_rem),
        .dvd_next(step_dvd)
    );

    // Sign fix-up of the unsigned quotient (dvd_reg) and remainder (rem_reg).
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign q_fix = neg_q_reg ? ({XLEN{1'b0}} - dvd_reg) : dvd_reg;
    assign r_fix = neg_r_reg ? ({XLEN{1'b0}} - rem_reg) : rem_reg;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs; kill overrides every transition.
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_next = DONE;
                    end else if (early_out) begin
                        state_next = FIX;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_reg == ITER_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill) begin
            state_next = IDLE;
        end
    end

    // Operand capture, iteration and result commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_reg     <= '0;
            dvd_reg     <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            funct3_reg  <= '0;
            rd_cap_reg  <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            rd_out_reg  <= '0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        funct3_reg  <= funct3;
                        rd_cap_reg  <= rd_in;
                        rem_reg     <= '0;
                        dvd_reg     <= a_mag;
                        divisor_reg <= b_mag;
                        cnt_reg     <= ITER_W'(XLEN);
                        neg_q_reg   <= a_neg ^ b_neg;
                        neg_r_reg   <= a_neg;
                        if (special) begin
                            result_reg <= special_res;
                            rd_out_reg <= rd_in;
                        end else if (early_out) begin
                            // Quotient 0, remainder |a|; FIX restores signs.
                            rem_reg <= a_mag;
                            dvd_reg <= '0;
                        end
                    end
                end
                CALC: begin
                    if (!kill) begin
                        rem_reg <= step_rem;
                        dvd_reg <= step_dvd;
                        cnt_reg <= cnt_reg - ITER_W'(1);
                    end
                end
                FIX: begin
                    if (!kill) begin
                        result_reg <= f3_is_rem(funct3_reg) ? r_fix : q_fix;
                        rd_out_reg <= rd_cap_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_out = rd_out_reg;
    assign result = result_reg;
    assign write  = done && (rd_out_reg != 5'd0);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit. Latency is counted as the
// cycle index in which done is seen, where the cycle right after the edge
// that samples start is cycle 1 (so the full path is 34, special cases 1).
module tb_div_unit;
    import div_pkg::*;

    localparam int NORM_LAT = 34;
    localparam int SPEC_LAT = 1;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        write;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    div_unit #(.XLEN(32)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .write  (write),
        .rd_out (rd_out),
        .result (result)
    );

    always #5 clock = ~clock;

    // Issue one operation and wait (bounded) for done; report what was seen.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [31:0] res,
                          output logic wr, output logic [4:0] rdo, output logic pulse_ok);
        @(negedge clock);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        res = result; wr = write; rdo = rd_out;
        @(posedge clock); #1;
        pulse_ok = (done === 1'b0) && (busy === 1'b0);
        $display("[TB] op f3=%b a=%h b=%h rd=%0d -> result=%h write=%b rd_out=%0d cycle=%0d",
                 f3, a, b, rd, res, wr, rdo, lat);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = 3'b000; op_a = '0; op_b = '0; rd_in = '0;
        #12;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write: got %b expected 0", write); end
        tests++; if (rd_out !== 5'd0) begin fails++; $display("FAIL reset_rd_out: got %0d expected 0", rd_out); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_divu();
        int lat; logic [31:0] res; logic wr; logic [4:0] rdo; logic ok;
        run_op(F3_DIVU, 32'd100, 32'd7, 5'd5, lat, res, wr, rdo, ok);
        tests++; if (lat != NORM_LAT) begin fails++; $display("FAIL divu_latency: got %0d expected %0d", lat, NORM_LAT); end
        tests++; if (res !== 32'd14) begin fails++; $display("FAIL divu_result: got %h expected %h", res, 32'd14); end
        tests++; if (wr !== 1'b1) begin fails++; $display("FAIL divu_write: got %b expected 1", wr); end
        tests++; if (rdo !== 5'd5) begin fails++; $display("FAIL divu_rd_out: got %0d expected 5", rdo); end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL divu_single_pulse: got %b expected 1", ok); end
        run_op(F3_REMU, 32'd100, 32'd7, 5'd6, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'd2) begin fails++; $display("FAIL remu_result: got %h expected %h", res, 32'd2); end
        tests++; if (rdo !== 5'd6) begin fails++; $display("FAIL remu_rd_out: got %0d expected 6", rdo); end
    endtask

    task automatic test_signed();
        int lat; logic [31:0] res; logic wr; logic [4:0] rdo; logic ok;
        run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg7_2: got %h expected %h", res, 32'hFFFF_FFFD); end
        tests++; if (lat != NORM_LAT) begin fails++; $display("FAIL div_signed_latency: got %0d expected %0d", lat, NORM_LAT); end
        run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_neg7_2: got %h expected %h", res, 32'hFFFF_FFFF); end
        run_op(F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd1, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'd1) begin fails++; $display("FAIL rem_7_neg2: got %h expected %h", res, 32'd1); end
        run_op(F3_DIV, 32'd7, 32'hFFFF_FFFE, 5'd1, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_7_neg2: got %h expected %h", res, 32'hFFFF_FFFD); end
    endtask

    task automatic test_special();
        int lat; logic [31:0] res; logic wr; logic [4:0] rdo; logic ok;
        run_op(F3_DIV, 32'd5, 32'd0, 5'd2, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_by_zero: got %h expected %h", res, 32'hFFFF_FFFF); end
        tests++; if (lat != SPEC_LAT) begin fails++; $display("FAIL div_by_zero_latency: got %0d expected %0d", lat, SPEC_LAT); end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL div_by_zero_pulse: got %b expected 1", ok); end
        run_op(F3_REMU, 32'h0000_1234, 32'd0, 5'd2, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'h0000_1234) begin fails++; $display("FAIL remu_by_zero: got %h expected %h", res, 32'h1234); end
        tests++; if (lat != SPEC_LAT) begin fails++; $display("FAIL remu_by_zero_latency: got %0d expected %0d", lat, SPEC_LAT); end
        run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'h8000_0000) begin fails++; $display("FAIL div_overflow: got %h expected %h", res, 32'h8000_0000); end
        tests++; if (lat != SPEC_LAT) begin fails++; $display("FAIL div_overflow_latency: got %0d expected %0d", lat, SPEC_LAT); end
        tests++; if (rdo !== 5'd3) begin fails++; $display("FAIL div_overflow_rd_out: got %0d expected 3", rdo); end
        run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'd0) begin fails++; $display("FAIL rem_overflow: got %h expected 0", res); end
        tests++; if (lat != SPEC_LAT) begin fails++; $display("FAIL rem_overflow_latency: got %0d expected %0d", lat, SPEC_LAT); end
    endtask

    task automatic test_early_out();
        int lat; logic [31:0] res; logic wr; logic [4:0] rdo; logic ok;
        run_op(F3_DIVU, 32'd3, 32'd10, 5'd8, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'd0) begin fails++; $display("FAIL small_divu: got %h expected 0", res); end
        tests++; if (lat != EARLY_LAT) begin fails++; $display("FAIL small_divu_latency: got %0d expected %0d", lat, EARLY_LAT); end
        run_op(F3_REMU, 32'd3, 32'd10, 5'd8, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'd3) begin fails++; $display("FAIL small_remu: got %h expected 3", res); end
        tests++; if (lat != EARLY_LAT) begin fails++; $display("FAIL small_remu_latency: got %0d expected %0d", lat, EARLY_LAT); end
        run_op(F3_REM, 32'hFFFF_FFFD, 32'd10, 5'd8, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'hFFFF_FFFD) begin fails++; $display("FAIL small_rem_signed: got %h expected %h", res, 32'hFFFF_FFFD); end
    endtask

    task automatic test_start_ignored();
        int npulse; logic [31:0] res;
        npulse = 0; res = '0;
        @(negedge clock);
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c < 60; c++) begin
            if (c >= 5 && c < 8) begin
                start = 1'b1; op_a = 32'd50; op_b = 32'd1; rd_in = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            if (done === 1'b1) begin
                npulse++;
                res = result;
            end
        end
        start = 1'b0;
        $display("[TB] op restart-during-calc -> result=%h pulses=%0d", res, npulse);
        tests++; if (npulse != 1) begin fails++; $display("FAIL restart_pulses: got %0d expected 1", npulse); end
        tests++; if (res !== 32'd14) begin fails++; $display("FAIL restart_result: got %h expected %h", res, 32'd14); end
        tests++; if (rd_out !== 5'd3) begin fails++; $display("FAIL restart_rd_out: got %0d expected 3", rd_out); end
    endtask

    task automatic test_kill();
        int npulse;
        npulse = 0;
        @(negedge clock);
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clock); #1; end
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL kill_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL kill_done: got %b expected 0", done); end
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (done === 1'b1) npulse++;
        end
        $display("[TB] op kill-at-cycle-10 -> result=%h rd_out=%0d pulses=%0d", result, rd_out, npulse);
        tests++; if (npulse != 0) begin fails++; $display("FAIL kill_pulses: got %0d expected 0", npulse); end
        tests++; if (result !== 32'd14) begin fails++; $display("FAIL kill_result_held: got %h expected %h", result, 32'd14); end
        tests++; if (rd_out !== 5'd3) begin fails++; $display("FAIL kill_rd_out_held: got %0d expected 3", rd_out); end
    endtask

    task automatic test_async_reset();
        int lat; logic [31:0] res; logic wr; logic [4:0] rdo; logic ok;
        @(negedge clock);
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] op async-reset-mid-calc -> busy=%b result=%h rd_out=%0d", busy, result, rd_out);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy: got %b expected 0", busy); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL areset_result: got %h expected 0", result); end
        tests++; if (rd_out !== 5'd0) begin fails++; $display("FAIL areset_rd_out: got %0d expected 0", rd_out); end
        #3 reset_n = 1'b1;
        run_op(F3_DIVU, 32'd9, 32'd3, 5'd4, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'd3) begin fails++; $display("FAIL after_reset_divu: got %h expected 3", res); end
        tests++; if (lat != NORM_LAT) begin fails++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, NORM_LAT); end
    endtask

    task automatic test_rd_zero();
        int lat; logic [31:0] res; logic wr; logic [4:0] rdo; logic ok;
        run_op(F3_DIVU, 32'd20, 32'd4, 5'd0, lat, res, wr, rdo, ok);
        tests++; if (lat != NORM_LAT) begin fails++; $display("FAIL rd0_done_latency: got %0d expected %0d", lat, NORM_LAT); end
        tests++; if (res !== 32'd5) begin fails++; $display("FAIL rd0_result: got %h expected 5", res); end
        tests++; if (wr !== 1'b0) begin fails++; $display("FAIL rd0_write: got %b expected 0", wr); end
    endtask

    task automatic test_other_funct3();
        int lat; logic [31:0] res; logic wr; logic [4:0] rdo; logic ok;
        run_op(3'b000, 32'hFFFF_FFF0, 32'd16, 5'd10, lat, res, wr, rdo, ok);
        tests++; if (res !== 32'h0FFF_FFFF) begin fails++; $display("FAIL other_f3_as_divu: got %h expected %h", res, 32'h0FFF_FFFF); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_special();
        test_early_out();
        test_start_ignored();
        test_kill();
        test_async_reset();
        test_rd_zero();
        test_other_funct3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
